// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg
//   Shared encodings for the parametrised serial sequence generator:
//   emission modes as seen on the mode port, and the controller state enum.
package seq_gen_pkg;

  localparam logic [1:0] MODE_ROT     = 2'd0;
  localparam logic [1:0] MODE_LFSR    = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;
  // Encoding 3 is not named on purpose: the shift core treats it as rotate.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shift_core.sv
// seq_shift_core
//   W-bit pattern register with parallel load and a mode-dependent
//   next-value function. It holds no sequencing state of its own; the
//   parent decides when to load and when to shift.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (q <= INIT)
//   load   in   parallel load q <= d (wins over shift)
//   d      in   W-bit pattern / LFSR seed
//   shift  in   advance q by one step
//   mode   in   0 rotate, 1 LFSR, 2 one-shot, 3 rotate
//   taps   in   LFSR feedback tap mask
//   q      out  current register contents, q[W-1] is the next serial bit
module seq_shift_core
  import seq_gen_pkg::*;
#(
  parameter int             W    = 6,
  parameter logic [W-1:0]   INIT = 6'b100111
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         shift,
  input  logic [1:0]   mode,
  input  logic [W-1:0] taps,
  output logic [W-1:0] q
);

  logic [W-1:0] q_next;

  // All modes shift left so the pattern leaves MSB-first; they differ only
  // in what enters at bit 0.
  always_comb begin
    q_next = {q[W-2:0], q[W-1]};
    case (mode)
      MODE_LFSR:    q_next = {q[W-2:0], ^(q & taps)};
      MODE_ONESHOT: q_next = {q[W-2:0], 1'b0};
      default:      q_next = {q[W-2:0], q[W-1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= INIT;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/seq_gen_param.sv
// seq_gen_param
//   Serial sequence generator. A start in IDLE emits the current register
//   contents MSB-first for reps W-bit periods (reps = 0: until stop), in
//   rotate, LFSR or one-shot mode, then pulses done for one cycle.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting; load writes the pattern, start begins emission
//   ST_RUN  | shifting one bit per clock, counting bits and periods
//   ST_DONE | one-cycle completion pulse, inputs ignored, back to IDLE
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   load   in   in IDLE: pattern register <= d (priority over start)
//   d      in   W-bit pattern / LFSR seed
//   taps   in   LFSR tap mask, captured on start
//   mode   in   emission mode, captured on start
//   start  in   in IDLE: begin emission from the current pattern
//   reps   in   number of W-bit periods, 0 = endless; captured on start
//   stop   in   in RUN: abort at the next edge without done
//   out    out  serial bit, q[W-1] while busy, else 0
//   busy   out  high while emitting
//   done   out  one-cycle pulse after the final period
module seq_gen_param
  import seq_gen_pkg::*;
#(
  parameter int           W    = 6,
  parameter int           CW   = 8,
  parameter logic [W-1:0] INIT = 6'b100111
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  d,
  input  logic [W-1:0]  taps,
  input  logic [1:0]    mode,
  input  logic          start,
  input  logic [CW-1:0] reps,
  input  logic          stop,
  output logic          out,
  output logic          busy,
  output logic          done
);

  localparam int BW = $clog2(W);

  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] per_cnt;
  logic [1:0]    mode_r;
  logic [W-1:0]  taps_r;
  logic [CW-1:0] reps_r;
  logic [W-1:0]  q;

  logic          bit_wrap;
  logic [CW-1:0] per_cnt_inc;
  logic          last_period;
  logic          core_load;
  logic          core_shift;

  assign bit_wrap    = (bit_cnt == BW'(W - 1));
  assign per_cnt_inc = per_cnt + 1'b1;
  // With reps_r = 0 this never matches, so the period counter simply wraps.
  assign last_period = (reps_r != '0) && (per_cnt_inc == reps_r);

  assign core_load  = load && (state == ST_IDLE);
  assign core_shift = (state == ST_RUN);

  seq_shift_core #(
    .W    (W),
    .INIT (INIT)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (core_load),
    .d     (d),
    .shift (core_shift),
    .mode  (mode_r),
    .taps  (taps_r),
    .q     (q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      per_cnt <= '0;
      mode_r  <= MODE_ROT;
      taps_r  <= '0;
      reps_r  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!load && start) begin
            mode_r  <= mode;
            taps_r  <= taps;
            // One-shot drains the register once, so only a single period
            // makes sense regardless of reps.
            reps_r  <= (mode == MODE_ONESHOT) ? CW'(1) : reps;
            bit_cnt <= '0;
            per_cnt <= '0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (bit_wrap) begin
            bit_cnt <= '0;
            per_cnt <= per_cnt_inc;
            if (last_period) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // busy is registered and resets asynchronously, so out drops with it.
  assign out = busy & q[W-1];

endmodule

// File: tb/tb_seq_gen_param.sv
module tb_seq_gen_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // Instance A: default W=6
  logic       load_a = 1'b0;
  logic [5:0] d_a = '0;
  logic [5:0] taps_a = '0;
  logic [1:0] mode_a = '0;
  logic       start_a = 1'b0;
  logic [7:0] reps_a = '0;
  logic       stop_a = 1'b0;
  logic       out_a, busy_a, done_a;

  // Instance B: W=4 for the LFSR case
  logic       load_b = 1'b0;
  logic [3:0] d_b = '0;
  logic [3:0] taps_b = '0;
  logic [1:0] mode_b = '0;
  logic       start_b = 1'b0;
  logic [7:0] reps_b = '0;
  logic       stop_b = 1'b0;
  logic       out_b, busy_b, done_b;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt_a = 0, exp_done_a = 0;
  int done_cnt_b = 0;
  logic exp_a[$];
  logic exp_b[$];

  always #5 clk = ~clk;

  seq_gen_param dut_a (
    .clk(clk), .rst_n(rst_n), .load(load_a), .d(d_a), .taps(taps_a),
    .mode(mode_a), .start(start_a), .reps(reps_a), .stop(stop_a),
    .out(out_a), .busy(busy_a), .done(done_a)
  );

  seq_gen_param #(.W(4), .CW(8), .INIT(4'b1010)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load_b), .d(d_b), .taps(taps_b),
    .mode(mode_b), .start(start_b), .reps(reps_b), .stop(stop_b),
    .out(out_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) exp_a.push_back(pat[i]);
  endtask

  task automatic go_a(input logic [1:0] m, input logic [7:0] r);
    mode_a  = m;
    reps_a  = r;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  // Called in the first RUN cycle (n0 = cycle index after the start edge).
  task automatic wait_done_a(input string name, input int n0, input int exp_n);
    int n = n0;
    while (!done_a && n < 300) begin
      tick();
      n++;
    end
    check({name, "_done_cycle"}, n, exp_n);
    exp_done_a++;
    tick();
    check({name, "_done_pulse_width"}, {30'd0, done_a, busy_a}, 0);
    check({name, "_done_count"}, done_cnt_a, exp_done_a);
  endtask

  // Scoreboard monitors: pop one expected bit for each busy cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_a) begin
        if (exp_a.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL a_unexpected_busy: got busy=1 expected no pending bits at %0t", $time);
        end else begin
          check("a_serial_bit", out_a, exp_a.pop_front());
        end
      end
      if (done_a) begin
        done_cnt_a++;
        check("a_done_with_busy", busy_a, 0);
      end
      if (busy_b) begin
        if (exp_b.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL b_unexpected_busy: got busy=1 expected no pending bits at %0t", $time);
        end else begin
          check("b_serial_bit", out_b, exp_b.pop_front());
        end
      end
      if (done_b) done_cnt_b++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Idle after reset: nothing emitted
    for (int i = 0; i < 6; i++) begin
      check("reset_idle_a", {out_a, busy_a, done_a}, 3'b000);
      check("reset_idle_b", {out_b, busy_b, done_b}, 3'b000);
      tick();
    end

    // Rotate from INIT, two periods
    push_a(32'h9E7, 12);
    go_a(2'd0, 8'd2);
    wait_done_a("rot2", 1, 13);

    // Mode 3 behaves as rotate; q back at INIT after two full periods
    push_a(32'b100111, 6);
    go_a(2'd3, 8'd1);
    wait_done_a("mode3", 1, 7);

    // One-shot: reps forced to one period, register drains to zero
    load_a = 1'b1;
    d_a = 6'b101100;
    tick();
    load_a = 1'b0;
    check("load_out_zero", {out_a, busy_a}, 2'b00);
    push_a(32'b101100, 6);
    go_a(2'd2, 8'd5);
    wait_done_a("oneshot", 1, 7);

    // Restart continues from the current q (all zeros)
    push_a(32'b000000, 6);
    go_a(2'd0, 8'd1);
    wait_done_a("after_oneshot", 1, 7);

    // load and start together: load wins, stay idle
    load_a = 1'b1;
    d_a = 6'b110001;
    mode_a = 2'd0;
    reps_a = 8'd1;
    start_a = 1'b1;
    tick();
    load_a = 1'b0;
    start_a = 1'b0;
    check("load_start_idle", {busy_a, done_a}, 2'b00);
    tick();
    check("load_start_idle2", {busy_a, done_a}, 2'b00);

    // load during RUN is ignored
    push_a(32'b110001, 6);
    go_a(2'd0, 8'd1);
    tick();
    load_a = 1'b1;
    d_a = 6'b000011;
    tick();
    tick();
    load_a = 1'b0;
    wait_done_a("load_in_run", 4, 7);

    // stop on the last bit beats end-of-run: no done
    push_a(32'b110001, 6);
    go_a(2'd0, 8'd1);
    repeat (5) tick();
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    check("stop_prio_busy", {busy_a, done_a}, 2'b00);
    tick();
    check("stop_prio_nodone", {busy_a, done_a}, 2'b00);
    tick();
    check("stop_prio_done_count", done_cnt_a, exp_done_a);

    // Endless rotate stopped after 3 bits; q keeps the shifted value
    push_a(32'b110, 3);
    go_a(2'd0, 8'd0);
    tick();
    tick();
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    check("stop_busy", {busy_a, done_a}, 2'b00);
    push_a(32'b001110, 6);
    go_a(2'd0, 8'd1);
    wait_done_a("after_stop", 1, 7);

    // Reset mid-run clears outputs at once and restores INIT
    push_a(32'b0011, 4);
    go_a(2'd0, 8'd0);
    repeat (3) tick();
    #5;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {out_a, busy_a, done_a}, 3'b000);
    repeat (2) tick();
    check("in_reset_outputs", {out_a, busy_a, done_a}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("after_reset_idle", {out_a, busy_a, done_a}, 3'b000);
    push_a(32'b100111, 6);
    go_a(2'd0, 8'd1);
    wait_done_a("after_reset", 1, 7);
    check("a_queue_drained", exp_a.size(), 0);

    // W=4 LFSR, seed 0001, taps 1001, endless, stopped after 20 bits
    load_b = 1'b1;
    d_b = 4'b0001;
    tick();
    load_b = 1'b0;
    check("b_load_out_zero", {out_b, busy_b}, 2'b00);
    for (int i = 19; i >= 0; i--) begin
      logic [19:0] lfsr_bits;
      lfsr_bits = 20'h1EB23;
      exp_b.push_back(lfsr_bits[i]);
    end
    taps_b = 4'b1001;
    mode_b = 2'd1;
    reps_b = 8'd0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (19) tick();
    stop_b = 1'b1;
    tick();
    stop_b = 1'b0;
    check("b_stop_busy", {busy_b, done_b}, 2'b00);
    repeat (3) tick();
    check("b_no_done", done_cnt_b, 0);
    check("b_queue_drained", exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
